// File: rtl/ewb_pkg.sv
// ---------------------------------------------------------------------------
// ewb_pkg
// Shared definitions for the parametric eviction write buffer: the controller
// state encoding and the default parameter values used by parametric_ewb and
// its address matcher.
// ---------------------------------------------------------------------------
package ewb_pkg;

    // Controller states. A 3-bit encoding leaves room for the five states used.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_ACCEPT = 3'd1,
        RD_FWD    = 3'd2,
        RD_MEM    = 3'd3,
        DRAIN     = 3'd4
    } ewb_state_e;

    // Default geometry of the buffer.
    localparam int EWB_ADDR_W = 32;
    localparam int EWB_LINE_W = 256;
    localparam int EWB_DEPTH  = 4;

endpackage

// File: rtl/ewb_match.sv
// ---------------------------------------------------------------------------
// ewb_match
// Combinational associative lookup of one address against every buffered
// entry. Only valid entries can match. The buffer never holds two valid
// entries with the same address (writes to a buffered address overwrite the
// existing entry), so the hit vector is at most one-hot and the encoder can
// simply OR together the indices of set bits.
//
// Ports
//   addr        in   ADDR_W        address being looked up
//   entry_addr  in   ADDR_W x DEPTH stored entry addresses
//   entry_valid in   DEPTH         per-entry valid bits
//   hit_vec     out  DEPTH         per-entry match
//   hit_idx     out  log2(DEPTH)   index of the matching entry (0 when none)
// ---------------------------------------------------------------------------
module ewb_match #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic [ADDR_W-1:0]        entry_addr [DEPTH],
    input  logic [DEPTH-1:0]         entry_valid,
    output logic [DEPTH-1:0]         hit_vec,
    output logic [$clog2(DEPTH)-1:0] hit_idx
);

    localparam int IDX_W = $clog2(DEPTH);

    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = entry_valid[i] && (entry_addr[i] == addr);
        end
        // One-hot hit vector: OR-ing indices yields the single matching one.
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_vec[i]) begin
                hit_idx = hit_idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/parametric_ewb.sv
// ---------------------------------------------------------------------------
// parametric_ewb
// Eviction write buffer between an L2 cache and physical memory. Dirty-line
// writebacks from L2 are absorbed into a DEPTH-entry FIFO and drained to
// memory whenever the L2 side is quiet. Reads that hit a buffered line are
// forwarded from the buffer; other reads pass through to memory. Writes to a
// line already buffered coalesce in place, keeping its drain position.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   L2_addr/L2_wdata              L2 request address / write line
//   L2_read/L2_write              L2 request strobes, held until L2_resp
//   L2_rdata/L2_resp              L2 read line / one-cycle response pulse
//   pmem_addr/pmem_wdata          memory request address / write line
//   pmem_read/pmem_write          memory request strobes
//   pmem_rdata/pmem_resp          memory read line / response
// ---------------------------------------------------------------------------
module parametric_ewb
    import ewb_pkg::*;
#(
    parameter int ADDR_W = EWB_ADDR_W,
    parameter int LINE_W = EWB_LINE_W,
    parameter int DEPTH  = EWB_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] L2_addr,
    input  logic [LINE_W-1:0] L2_wdata,
    input  logic              L2_read,
    input  logic              L2_write,
    output logic [LINE_W-1:0] L2_rdata,
    output logic              L2_resp,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ewb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [DEPTH-1:0]   valid_q;

    // Entry payload storage; only the valid bits carry meaning after reset.
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [LINE_W-1:0]  data_q [DEPTH];

    logic [DEPTH-1:0]   hit_vec;
    logic [PTR_W-1:0]   hit_idx;
    logic               hit;
    logic               full;
    logic               wr_new;
    logic               wr_coal;
    logic               drain_done;

    ewb_match #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_match (
        .addr        (L2_addr),
        .entry_addr  (addr_q),
        .entry_valid (valid_q),
        .hit_vec     (hit_vec),
        .hit_idx     (hit_idx)
    );

    assign hit  = |hit_vec;
    assign full = (count_q == CNT_W'(DEPTH));

    // The L2 address is held for the whole request, so the hit decision made
    // in IDLE is still valid in WR_ACCEPT/RD_FWD. The !full guard is defensive.
    assign wr_new     = (state_q == WR_ACCEPT) && !hit && !full;
    assign wr_coal    = (state_q == WR_ACCEPT) && hit;
    assign drain_done = (state_q == DRAIN) && pmem_resp;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (L2_read) begin
                    state_d = hit ? RD_FWD : RD_MEM;
                end else if (L2_write) begin
                    // A full buffer must free its oldest entry before a new
                    // line can be taken; a coalescing write never needs room.
                    state_d = (hit || !full) ? WR_ACCEPT : DRAIN;
                end else if (count_q != '0) begin
                    state_d = DRAIN;
                end
            end
            WR_ACCEPT: state_d = IDLE;
            RD_FWD:    state_d = IDLE;
            RD_MEM:    if (pmem_resp) state_d = IDLE;
            // A started drain always completes; pending L2 work waits in IDLE.
            DRAIN:     if (pmem_resp) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (wr_new) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
                count_q         <= count_q + CNT_W'(1);
            end else if (drain_done) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
                count_q         <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_new) begin
            addr_q[tail_q] <= L2_addr;
            data_q[tail_q] <= L2_wdata;
        end else if (wr_coal) begin
            data_q[hit_idx] <= L2_wdata;
        end
    end

    // Outputs decode from state; IDLE (the reset state) drives everything low.
    always_comb begin
        L2_rdata   = '0;
        L2_resp    = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        unique case (state_q)
            WR_ACCEPT: begin
                L2_resp = 1'b1;
            end
            RD_FWD: begin
                L2_resp  = 1'b1;
                L2_rdata = data_q[hit_idx];
            end
            RD_MEM: begin
                pmem_read = 1'b1;
                pmem_addr = L2_addr;
                L2_rdata  = pmem_rdata;
                L2_resp   = pmem_resp;
            end
            DRAIN: begin
                pmem_write = 1'b1;
                pmem_addr  = addr_q[head_q];
                pmem_wdata = data_q[head_q];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_parametric_ewb.sv
// ---------------------------------------------------------------------------
// tb_parametric_ewb
// Bench for parametric_ewb: a directed vector table, hand-written corner
// sequences (slow memory read, reset during drain) and a randomized phase
// scored against an ordered-list model of the buffer plus a memory model.
// ---------------------------------------------------------------------------
module tb_parametric_ewb;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 64;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] L2_addr;
    logic [LINE_W-1:0] L2_wdata;
    logic              L2_read;
    logic              L2_write;
    logic [LINE_W-1:0] L2_rdata;
    logic              L2_resp;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    parametric_ewb #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .L2_addr    (L2_addr),
        .L2_wdata   (L2_wdata),
        .L2_read    (L2_read),
        .L2_write   (L2_write),
        .L2_rdata   (L2_rdata),
        .L2_resp    (L2_resp),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- memory model ----------------
    logic [LINE_W-1:0] mem [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] log_a [$];
    logic [LINE_W-1:0] log_d [$];
    int  lat_target = 3;
    bit  lat_random = 0;

    function automatic logic [LINE_W-1:0] line_default(input logic [ADDR_W-1:0] a);
        return {a, ~a};
    endfunction

    function automatic logic [LINE_W-1:0] mem_value(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return line_default(a);
    endfunction

    // Responds to a memory request after lat_target cycles of it being held.
    initial begin
        int lat_cnt;
        lat_cnt    = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            pmem_resp = 1'b0;
            if (!rst_n || !(pmem_read || pmem_write)) begin
                lat_cnt = 0;
                continue;
            end
            lat_cnt++;
            if (lat_cnt >= lat_target) begin
                lat_cnt   = 0;
                pmem_resp = 1'b1;
                if (pmem_write) begin
                    log_a.push_back(pmem_addr);
                    log_d.push_back(pmem_wdata);
                    mem[pmem_addr] = pmem_wdata;
                end else begin
                    pmem_rdata = mem_value(pmem_addr);
                end
                if (lat_random) lat_target = $urandom_range(1, 4);
            end
        end
    end

    // ---------------- buffer model: ordered list of buffered lines ----------------
    logic [ADDR_W-1:0] mq_a [$];
    logic [LINE_W-1:0] mq_d [$];
    int drains_seen = 0;
    int drains_100  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_find(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < mq_a.size(); i++) begin
            if (mq_a[i] == a) return i;
        end
        return -1;
    endfunction

    // Every memory write must be the oldest buffered line with its latest data.
    task automatic model_sync();
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        while (log_a.size() > 0) begin
            a = log_a.pop_front();
            d = log_d.pop_front();
            drains_seen++;
            if (a == 32'h100) drains_100++;
            if (mq_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_unexpected: got addr 0x%0h with empty buffer", a);
            end else begin
                chk("drain_addr", a, mq_a[0]);
                chk("drain_data", d, mq_d[0]);
                void'(mq_a.pop_front());
                void'(mq_d.pop_front());
            end
        end
    endtask

    // Issues one request at posedge+1 and waits for L2_resp; returns at
    // posedge+1 of the cycle after the response with the strobes dropped.
    task automatic do_req(input bit rd, input bit wr,
                          input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                          output int lat, output logic [LINE_W-1:0] rdata,
                          output int prd, output bit presp, output bit ok);
        L2_addr  = a;
        L2_wdata = d;
        L2_read  = rd;
        L2_write = wr;
        lat = 0; prd = 0; ok = 0; presp = 0; rdata = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (pmem_read) prd++;
            if (L2_resp) begin
                ok    = 1;
                lat   = c;
                rdata = L2_rdata;
                presp = pmem_resp;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: addr 0x%0h no L2_resp within 300 cycles", a);
        end
        @(posedge clk);
        #1;
        L2_read  = 1'b0;
        L2_write = 1'b0;
    endtask

    // Scores a completed request against the models.
    task automatic model_apply(input bit rd, input logic [ADDR_W-1:0] a,
                               input logic [LINE_W-1:0] d, input logic [LINE_W-1:0] rdata,
                               input int prd);
        int idx;
        model_sync();
        idx = model_find(a);
        if (rd) begin
            chk("rd_data", rdata, (idx >= 0) ? mq_d[idx] : mem_value(a));
            chk("rd_uses_pmem", prd > 0, idx < 0);
        end else begin
            chk("wr_no_pmem_read", prd, 0);
            if (idx >= 0) begin
                mq_d[idx] = d;
            end else if (mq_a.size() < DEPTH) begin
                mq_a.push_back(a);
                mq_d.push_back(d);
            end else begin
                checks++;
                errors++;
                $display("FAIL wr_overflow: addr 0x%0h accepted with buffer full", a);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit                rd;
        bit                wr;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        int                exp_lat;
        logic [LINE_W-1:0] exp_rdata;
        int                exp_prd;
        int                exp_cnt;
    } vec_t;

    localparam logic [LINE_W-1:0] D1 = 64'h1111_0000_0000_0001;
    localparam logic [LINE_W-1:0] D2 = 64'h2222_0000_0000_0002;
    localparam logic [LINE_W-1:0] D3 = 64'h3333_0000_0000_0003;
    localparam logic [LINE_W-1:0] D4 = 64'h4444_0000_0000_0004;
    localparam logic [LINE_W-1:0] D5 = 64'h5555_0000_0000_0005;
    localparam logic [LINE_W-1:0] D6 = 64'h6666_0000_0000_0006;
    localparam logic [LINE_W-1:0] D7 = 64'h7777_0000_0000_0007;
    localparam logic [LINE_W-1:0] D8 = 64'h8888_0000_0000_0008;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        int lat, prd;
        bit presp, ok;
        logic [LINE_W-1:0] rdata;
        logic [ADDR_W-1:0] ra;
        logic [LINE_W-1:0] rd_d;
        bit rrd, rwr;
        int kind;

        // Back-to-back directed vectors, memory latency 3.
        vecs[0]  = '{1'b0, 1'b1, 32'h100, D1, 1, '0, 0, 1};
        vecs[1]  = '{1'b1, 1'b0, 32'h100, '0, 1, D1, 0, 1};
        vecs[2]  = '{1'b0, 1'b1, 32'h100, D2, 1, '0, 0, 1};
        vecs[3]  = '{1'b0, 1'b1, 32'h200, D3, 1, '0, 0, 2};
        vecs[4]  = '{1'b0, 1'b1, 32'h300, D4, 1, '0, 0, 3};
        vecs[5]  = '{1'b0, 1'b1, 32'h400, D5, 1, '0, 0, 4};
        vecs[6]  = '{1'b0, 1'b1, 32'h200, D6, 1, '0, 0, 4};   // coalesce while full
        vecs[7]  = '{1'b0, 1'b1, 32'h500, D7, 5, '0, 0, 4};   // stall behind a drain
        vecs[8]  = '{1'b1, 1'b0, 32'h100, '0, 3, D2, 3, 4};   // drained line from memory
        vecs[9]  = '{1'b1, 1'b0, 32'h740, '0, 3, {32'h740, ~32'h740}, 3, 4};
        vecs[10] = '{1'b1, 1'b0, 32'h200, '0, 1, D6, 0, 4};
        vecs[11] = '{1'b1, 1'b1, 32'h300, D8, 1, D4, 0, 4};   // read wins over write

        rst_n = 1'b0;
        L2_addr = '0; L2_wdata = '0; L2_read = 1'b0; L2_write = 1'b0;
        #2;
        chk("rst_l2_resp", L2_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr", pmem_addr, 0);
        chk("rst_count", dut.count_q, 0);
        chk("rst_valid", dut.valid_q, 0);
        idle(2);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, lat, rdata, prd, presp, ok);
            if (ok) begin
                chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
                chk($sformatf("v%0d_pmem_read_cycles", i), prd, vecs[i].exp_prd);
                if (vecs[i].rd) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
                model_apply(vecs[i].rd, vecs[i].a, vecs[i].d, rdata, prd);
                chk($sformatf("v%0d_count", i), dut.count_q, vecs[i].exp_cnt);
            end
        end

        // Quiet L2: the remaining four lines drain oldest first.
        idle(40);
        model_sync();
        chk("drain_all_total", drains_seen, 5);
        chk("drain_0x100_once", drains_100, 1);
        chk("drain_all_count", dut.count_q, 0);
        chk("drain_all_model_empty", mq_a.size(), 0);

        // Slow memory read miss: pmem_read held for five cycles.
        lat_target = 5;
        do_req(1'b1, 1'b0, 32'h700, '0, lat, rdata, prd, presp, ok);
        if (ok) begin
            chk("slow_rd_latency", lat, 5);
            chk("slow_rd_pmem_read_cycles", prd, 5);
            chk("slow_rd_resp_with_pmem", presp, 1);
            chk("slow_rd_data", rdata, {32'h700, ~32'h700});
        end
        lat_target = 3;

        // Reset while a drain is outstanding.
        lat_target = 50;
        do_req(1'b0, 1'b1, 32'h900, D1, lat, rdata, prd, presp, ok);
        if (ok) model_apply(1'b0, 32'h900, D1, rdata, prd);
        do_req(1'b0, 1'b1, 32'hA00, D2, lat, rdata, prd, presp, ok);
        if (ok) model_apply(1'b0, 32'hA00, D2, rdata, prd);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_drain_active", pmem_write, 1);
        chk("pre_rst_drain_addr", pmem_addr, 32'h900);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pmem_write", pmem_write, 0);
        chk("mid_rst_pmem_addr", pmem_addr, 0);
        chk("mid_rst_count", dut.count_q, 0);
        chk("mid_rst_valid", dut.valid_q, 0);
        mq_a.delete();
        mq_d.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        lat_target = 3;
        @(posedge clk);
        #1;
        do_req(1'b1, 1'b0, 32'h900, '0, lat, rdata, prd, presp, ok);
        if (ok) begin
            chk("post_rst_rd_pmem_cycles", prd, 3);
            chk("post_rst_rd_data", rdata, {32'h900, ~32'h900});
            model_apply(1'b1, 32'h900, '0, rdata, prd);
        end

        // Randomized traffic over a small address pool to force hits and stalls.
        lat_random = 1;
        for (int n = 0; n < 400; n++) begin
            ra   = 32'h1000 + 32'h100 * $urandom_range(0, 7);
            rd_d = {$urandom, $urandom};
            kind = $urandom_range(0, 99);
            rrd  = (kind < 40) || (kind >= 90);
            rwr  = (kind >= 40);
            do_req(rrd, rwr, ra, rd_d, lat, rdata, prd, presp, ok);
            if (ok) begin
                model_apply(rrd, ra, rd_d, rdata, prd);
                chk("rand_count", dut.count_q, mq_a.size());
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
        end
        idle(200);
        model_sync();
        chk("rand_final_count", dut.count_q, 0);
        chk("rand_final_model_empty", mq_a.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
